// File: rtl/bp_fe_icache_cce_responder.sv
// ---------------------------------------------------------------------------
// bp_fe_icache_cce_responder
//
// Minimal CCE-side responder for a single FE I-cache LCE. It accepts one
// miss (cached) or uncached load request, reads the line or dword from
// memory, and returns the data to the LCE as a data_and_tag or uc_data
// command. After a cached fill it waits for the LCE coherence ack before
// taking the next request, so at most one transaction is ever in flight.
//
// Optional feature macro: BP_FE_CCE_ACK_TIMEOUT_EN
//   defined   : WAIT_ACK gives up after ack_timeout_p cycles, sets the sticky
//               error_o and returns to IDLE.
//   undefined : WAIT_ACK waits indefinitely and error_o is tied low.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   cce_id_i                  this CCE's id (static), echoed on lce_cmd_src_o
//   lce_req_*                 incoming miss / uncached request (valid/ready)
//   mem_cmd_*                 memory read command (valid/ready)
//   mem_resp_*                memory read data (valid/yumi)
//   lce_cmd_*                 fill / uncached data command to LCE (valid/ready)
//   lce_resp_*                LCE responses, only coh_ack is meaningful (valid/yumi)
//   busy_o                    transaction in progress (FSM not IDLE)
//   error_o                   sticky ack-timeout flag
// ---------------------------------------------------------------------------
module bp_fe_icache_cce_responder #(
    parameter int paddr_width_p  = 40,
    parameter int block_width_p  = 512,
    parameter int dword_width_p  = 64,
    parameter int lce_id_width_p = 4,
    parameter int cce_id_width_p = 4,
    parameter int lce_assoc_p    = 8,
    parameter int ack_timeout_p  = 1024,
    localparam int way_w = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [cce_id_width_p-1:0] cce_id_i,

    input  logic                      lce_req_v_i,
    output logic                      lce_req_ready_o,
    input  logic [paddr_width_p-1:0]  lce_req_addr_i,
    input  logic                      lce_req_uc_i,
    input  logic [lce_id_width_p-1:0] lce_req_src_i,
    input  logic [way_w-1:0]          lce_req_way_i,

    output logic                      mem_cmd_v_o,
    input  logic                      mem_cmd_ready_i,
    output logic [paddr_width_p-1:0]  mem_cmd_addr_o,
    output logic                      mem_cmd_uc_o,

    input  logic                      mem_resp_v_i,
    output logic                      mem_resp_yumi_o,
    input  logic [block_width_p-1:0]  mem_resp_data_i,

    output logic                      lce_cmd_v_o,
    input  logic                      lce_cmd_ready_i,
    output logic [1:0]                lce_cmd_type_o,
    output logic [lce_id_width_p-1:0] lce_cmd_dst_o,
    output logic [cce_id_width_p-1:0] lce_cmd_src_o,
    output logic [way_w-1:0]          lce_cmd_way_o,
    output logic [paddr_width_p-1:0]  lce_cmd_addr_o,
    output logic [block_width_p-1:0]  lce_cmd_data_o,

    input  logic                      lce_resp_v_i,
    output logic                      lce_resp_yumi_o,
    input  logic [1:0]                lce_resp_type_i,

    output logic                      busy_o,
    output logic                      error_o
);

    localparam int offset_w = $clog2(block_width_p / 8);
    localparam int cnt_w    = $clog2(ack_timeout_p + 1);
    localparam logic [paddr_width_p-1:0] line_mask =
        {{(paddr_width_p - offset_w){1'b1}}, {offset_w{1'b0}}};

    localparam logic [1:0] cmd_data_and_tag = 2'b01;
    localparam logic [1:0] cmd_uc_data      = 2'b10;
    localparam logic [1:0] resp_coh_ack     = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_CMD  = 3'd1,
        S_MEM_RESP = 3'd2,
        S_LCE_CMD  = 3'd3,
        S_WAIT_ACK = 3'd4
    } state_e;

    state_e                      state_r;
    state_e                      state_nxt_s;
    // run_r is low while reset is asserted and for the first edge after it,
    // which keeps the always-ready/always-yumi outputs at 0 during reset.
    logic                        run_r;
    logic [paddr_width_p-1:0]    addr_r;
    logic                        uc_r;
    logic [lce_id_width_p-1:0]   src_r;
    logic [way_w-1:0]            way_r;
    logic [1:0]                  type_r;
    logic [block_width_p-1:0]    data_r;

    logic                        req_accept_s;
    logic                        resp_take_s;
    logic                        ack_s;
    logic                        timeout_s;
    logic                        ack_entry_s;
    logic [paddr_width_p-1:0]    line_addr_s;
    logic [block_width_p-1:0]    fill_data_s;

    assign line_addr_s = addr_r & line_mask;

    // Uncached responses carry only the low dword; zero-extend it.
    always_comb begin
        fill_data_s = mem_resp_data_i;
        if (uc_r) begin
            fill_data_s = {{(block_width_p - dword_width_p){1'b0}},
                           mem_resp_data_i[dword_width_p-1:0]};
        end else begin
            fill_data_s = mem_resp_data_i;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt_s  = state_r;
        req_accept_s = 1'b0;
        resp_take_s  = 1'b0;
        ack_s        = 1'b0;
        ack_entry_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run_r && lce_req_v_i) begin
                    req_accept_s = 1'b1;
                    state_nxt_s  = S_MEM_CMD;
                end else begin
                    state_nxt_s  = S_IDLE;
                end
            end
            S_MEM_CMD: begin
                if (mem_cmd_ready_i) begin
                    state_nxt_s = S_MEM_RESP;
                end else begin
                    state_nxt_s = S_MEM_CMD;
                end
            end
            S_MEM_RESP: begin
                if (mem_resp_v_i) begin
                    resp_take_s = 1'b1;
                    state_nxt_s = S_LCE_CMD;
                end else begin
                    state_nxt_s = S_MEM_RESP;
                end
            end
            S_LCE_CMD: begin
                if (lce_cmd_ready_i && uc_r) begin
                    state_nxt_s = S_IDLE;
                end else if (lce_cmd_ready_i) begin
                    ack_entry_s = 1'b1;
                    state_nxt_s = S_WAIT_ACK;
                end else begin
                    state_nxt_s = S_LCE_CMD;
                end
            end
            S_WAIT_ACK: begin
                // Non-ack responses are consumed by yumi but otherwise ignored.
                if (lce_resp_v_i && (lce_resp_type_i == resp_coh_ack)) begin
                    ack_s       = 1'b1;
                    state_nxt_s = S_IDLE;
                end else if (timeout_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT_ACK;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register and run qualifier.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= S_IDLE;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= 1'b1;
        end
    end

    // Request field capture and data latch.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_r <= '0;
            uc_r   <= 1'b0;
            src_r  <= '0;
            way_r  <= '0;
            type_r <= 2'b00;
            data_r <= '0;
        end else begin
            if (req_accept_s) begin
                addr_r <= lce_req_addr_i;
                uc_r   <= lce_req_uc_i;
                src_r  <= lce_req_src_i;
                way_r  <= lce_req_way_i;
                type_r <= lce_req_uc_i ? cmd_uc_data : cmd_data_and_tag;
            end
            if (resp_take_s) begin
                data_r <= fill_data_s;
            end
        end
    end

`ifdef BP_FE_CCE_ACK_TIMEOUT_EN
    logic [cnt_w-1:0] ack_cnt_r;
    logic             error_r;

    // The counter reaches ack_timeout_p on the edge that ends the
    // ack_timeout_p-th WAIT_ACK cycle; that same edge leaves WAIT_ACK.
    assign timeout_s = (state_r == S_WAIT_ACK) && !ack_s &&
                       (ack_cnt_r == cnt_w'(ack_timeout_p - 1));

    // WAIT_ACK cycle counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ack_cnt_r <= '0;
            error_r   <= 1'b0;
        end else begin
            if (ack_entry_s) begin
                ack_cnt_r <= '0;
            end else if (state_r == S_WAIT_ACK) begin
                ack_cnt_r <= ack_cnt_r + cnt_w'(1);
            end
            if (timeout_s) begin
                error_r <= 1'b1;
            end
        end
    end

    assign error_o = error_r;
`else
    logic [cnt_w-1:0] unused_timeout;
    logic             unused_ack_entry;

    assign unused_timeout   = cnt_w'(ack_timeout_p);
    assign unused_ack_entry = ack_entry_s;
    assign timeout_s        = 1'b0;
    assign error_o          = 1'b0;
`endif

    // Outputs decode from registered state and captured fields only,
    // except the yumi signals which must follow their valid inputs.
    assign lce_req_ready_o = run_r && (state_r == S_IDLE);
    assign mem_cmd_v_o     = (state_r == S_MEM_CMD);
    assign mem_cmd_addr_o  = uc_r ? addr_r : line_addr_s;
    assign mem_cmd_uc_o    = uc_r;
    assign mem_resp_yumi_o = mem_resp_v_i && (state_r == S_MEM_RESP);
    assign lce_cmd_v_o     = (state_r == S_LCE_CMD);
    assign lce_cmd_type_o  = type_r;
    assign lce_cmd_dst_o   = src_r;
    assign lce_cmd_src_o   = cce_id_i;
    assign lce_cmd_way_o   = way_r;
    assign lce_cmd_addr_o  = uc_r ? addr_r : line_addr_s;
    assign lce_cmd_data_o  = data_r;
    assign lce_resp_yumi_o = lce_resp_v_i && run_r;
    assign busy_o          = (state_r != S_IDLE);

endmodule
